control_sequencer: RTL and testbench

- Multi-cycle control unit directly upstream of the ALU.
- Steps each instruction through fetch and execute T-states and decodes IR[31:27].
- Drives the ALU opcode and the IncPC/branch inputs, plus every datapath register-enable, bus-drive and memory strobe.
- Owns the run/halt status of the processor.

---
 rtl/cpu_defs_pkg.sv | 120 ++++++++++++
 rtl/control_sequencer_decode.sv | 153 +++++++++++++++
 rtl/control_sequencer.sv | 124 ++++++++++++
 tb/tb_control_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control sequencer: opcodes, T-state encoding,
// instruction classes and the packed control-strobe bundle.
package cpu_defs;

    localparam int OPW = 5;
    localparam int IRW = 32;

    localparam logic [OPW-1:0] OP_LD     = 5'd0;
    localparam logic [OPW-1:0] OP_LDI    = 5'd1;
    localparam logic [OPW-1:0] OP_ST     = 5'd2;
    localparam logic [OPW-1:0] OP_ADD    = 5'd3;
    localparam logic [OPW-1:0] OP_SUB    = 5'd4;
    localparam logic [OPW-1:0] OP_AND    = 5'd5;
    localparam logic [OPW-1:0] OP_OR     = 5'd6;
    localparam logic [OPW-1:0] OP_SHR    = 5'd7;
    localparam logic [OPW-1:0] OP_SHRA   = 5'd8;
    localparam logic [OPW-1:0] OP_SHL    = 5'd9;
    localparam logic [OPW-1:0] OP_ROR    = 5'd10;
    localparam logic [OPW-1:0] OP_ROL    = 5'd11;
    localparam logic [OPW-1:0] OP_ADDI   = 5'd12;
    localparam logic [OPW-1:0] OP_ANDI   = 5'd13;
    localparam logic [OPW-1:0] OP_ORI    = 5'd14;
    localparam logic [OPW-1:0] OP_MUL    = 5'd15;
    localparam logic [OPW-1:0] OP_DIV    = 5'd16;
    localparam logic [OPW-1:0] OP_NEG    = 5'd17;
    localparam logic [OPW-1:0] OP_NOT    = 5'd18;
    localparam logic [OPW-1:0] OP_BRANCH = 5'd19;
    localparam logic [OPW-1:0] OP_JR     = 5'd20;
    localparam logic [OPW-1:0] OP_JAL    = 5'd21;
    localparam logic [OPW-1:0] OP_IN     = 5'd22;
    localparam logic [OPW-1:0] OP_OUT    = 5'd23;
    localparam logic [OPW-1:0] OP_MFHI   = 5'd24;
    localparam logic [OPW-1:0] OP_MFLO   = 5'd25;
    localparam logic [OPW-1:0] OP_NOP    = 5'd26;
    localparam logic [OPW-1:0] OP_HALT   = 5'd27;

    // T-states are consecutive so the sequencer can step by +1.
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_e;

    // Opcodes that share an execute sequence are grouped into one class.
    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BRANCH,
        C_JR, C_JAL, C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT
    } iclass_e;

    typedef struct packed {
        logic           run;
        logic [OPW-1:0] alu_opcode;
        logic           inc_pc;
        logic           br_flag;
        logic           pc_out;
        logic           mdr_out;
        logic           zhi_out;
        logic           zlo_out;
        logic           hi_out;
        logic           lo_out;
        logic           inport_out;
        logic           c_out;
        logic           pc_in;
        logic           mar_in;
        logic           mdr_in;
        logic           ir_in;
        logic           y_in;
        logic           z_in;
        logic           hi_in;
        logic           lo_in;
        logic           con_in;
        logic           outport_in;
        logic           gra;
        logic           grb;
        logic           grc;
        logic           r_in;
        logic           r_out;
        logic           ba_out;
        logic           read;
        logic           write;
    } ctrl_t;

    function automatic iclass_e op_class(input logic [OPW-1:0] op);
        iclass_e c;
        c = C_NOP;  // undefined opcodes behave as NOP
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL:         c = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:       c = C_IMM;
            OP_MUL, OP_DIV:                 c = C_MULDIV;
            OP_NEG, OP_NOT:                 c = C_UNARY;
            OP_LD:                          c = C_LD;
            OP_LDI:                         c = C_LDI;
            OP_ST:                          c = C_ST;
            OP_BRANCH:                      c = C_BRANCH;
            OP_JR:                          c = C_JR;
            OP_JAL:                         c = C_JAL;
            OP_MFHI:                        c = C_MFHI;
            OP_MFLO:                        c = C_MFLO;
            OP_IN:                          c = C_IN;
            OP_OUT:                         c = C_OUT;
            OP_HALT:                        c = C_HALT;
            default:                        c = C_NOP;
        endcase
        return c;
    endfunction

    // Final execute T-state of each class; the edge leaving it ends the instruction.
    function automatic state_e last_tstate(input iclass_e c);
        state_e s;
        s = S_T3;
        case (c)
            C_ALU3, C_IMM, C_LDI: s = S_T5;
            C_MULDIV, C_BRANCH:   s = S_T6;
            C_UNARY, C_JAL:       s = S_T4;
            C_LD, C_ST:           s = S_T7;
            default:              s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Purely combinational strobe decode from (T-state, opcode, con_ff).
module control_decode
    import cpu_defs::*;
(
    input  state_e         state_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           con_ff_i,
    output ctrl_t          ctrl_o
);

    iclass_e cls;
    assign cls = op_class(opcode_i);

    // Strobe decode: everything idle unless the current step names it.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl_o = '0;
        if (state_i inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7}) begin
            ctrl_o.run        = 1'b1;
            ctrl_o.alu_opcode = OP_NOP;
        end
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1; ctrl_o.pc_in  = 1'b1;
            end
            S_T1: begin
                ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU3, C_IMM: begin
                        ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1;
                        ctrl_o.alu_opcode = opcode_i; ctrl_o.z_in = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1;
                    end
                    C_BRANCH: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_in = 1'b1;
                    end
                    C_JR: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1;
                    end
                    C_JAL: begin
                        ctrl_o.pc_out = 1'b1; ctrl_o.grb = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl_o.hi_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_MFLO: begin
                        ctrl_o.lo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_IN: begin
                        ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_OUT: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU3: begin
                        ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1;
                        ctrl_o.alu_opcode = opcode_i; ctrl_o.z_in = 1'b1;
                    end
                    C_IMM: begin
                        ctrl_o.c_out = 1'b1; ctrl_o.alu_opcode = opcode_i; ctrl_o.z_in = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1;
                        ctrl_o.alu_opcode = opcode_i; ctrl_o.z_in = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl_o.zlo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        ctrl_o.c_out = 1'b1; ctrl_o.alu_opcode = OP_ADD; ctrl_o.z_in = 1'b1;
                    end
                    C_BRANCH: begin
                        ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1;
                    end
                    C_JAL: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin
                        ctrl_o.zlo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl_o.zlo_out = 1'b1; ctrl_o.lo_in = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ctrl_o.zlo_out = 1'b1; ctrl_o.mar_in = 1'b1;
                    end
                    C_BRANCH: begin
                        ctrl_o.c_out = 1'b1; ctrl_o.alu_opcode = OP_ADD; ctrl_o.z_in = 1'b1;
                        ctrl_o.br_flag = con_ff_i;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_MULDIV: begin
                        ctrl_o.zhi_out = 1'b1; ctrl_o.hi_in = 1'b1;
                    end
                    C_LD: begin
                        ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_in = 1'b1;
                    end
                    C_BRANCH: begin
                        // The branch target in Z is taken only when the condition holds.
                        ctrl_o.pc_in   = con_ff_i;
                        ctrl_o.zlo_out = con_ff_i;
                        ctrl_o.br_flag = con_ff_i;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                    end
                    C_ST: begin
                        ctrl_o.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: T-state register, next-state logic and
// fan-out of the decoded strobe bundle onto the datapath control pins.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [IRW-1:0] ir,
    input  logic           con_ff,
    input  logic           stop,
    output logic           run,
    output logic [OPW-1:0] alu_opcode,
    output logic           inc_pc,
    output logic           br_flag,
    output logic           pc_out,
    output logic           mdr_out,
    output logic           zhi_out,
    output logic           zlo_out,
    output logic           hi_out,
    output logic           lo_out,
    output logic           inport_out,
    output logic           c_out,
    output logic           pc_in,
    output logic           mar_in,
    output logic           mdr_in,
    output logic           ir_in,
    output logic           y_in,
    output logic           z_in,
    output logic           hi_in,
    output logic           lo_in,
    output logic           con_in,
    output logic           outport_in,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           r_in,
    output logic           r_out,
    output logic           ba_out,
    output logic           read,
    output logic           write
);

    state_e         state_q, state_d;
    logic [OPW-1:0] opcode;
    iclass_e        cls;
    ctrl_t          ctrl;
    logic           ir_unused;

    assign opcode = ir[IRW-1 -: OPW];
    assign cls    = op_class(opcode);
    // Operand fields are consumed by the datapath, not by the sequencer.
    assign ir_unused = ^ir[IRW-OPW-1:0];

    // State register; clr aborts any partial instruction immediately.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (clr) state_q <= S_RST;
        else     state_q <= state_d;
    end

    // Next T-state: fetch is fixed, execute length depends on the opcode class.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_tstate(cls)) begin
                    // Instruction end: HALT or a pending stop request parks the machine.
                    if (cls == C_HALT || stop) state_d = S_HALTED;
                    else                       state_d = S_T0;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RST;
        endcase
    end

    control_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .con_ff_i (con_ff),
        .ctrl_o   (ctrl)
    );

    assign run        = ctrl.run;
    assign alu_opcode = ctrl.alu_opcode;
    assign inc_pc     = ctrl.inc_pc;
    assign br_flag    = ctrl.br_flag;
    assign pc_out     = ctrl.pc_out;
    assign mdr_out    = ctrl.mdr_out;
    assign zhi_out    = ctrl.zhi_out;
    assign zlo_out    = ctrl.zlo_out;
    assign hi_out     = ctrl.hi_out;
    assign lo_out     = ctrl.lo_out;
    assign inport_out = ctrl.inport_out;
    assign c_out      = ctrl.c_out;
    assign pc_in      = ctrl.pc_in;
    assign mar_in     = ctrl.mar_in;
    assign mdr_in     = ctrl.mdr_in;
    assign ir_in      = ctrl.ir_in;
    assign y_in       = ctrl.y_in;
    assign z_in       = ctrl.z_in;
    assign hi_in      = ctrl.hi_in;
    assign lo_in      = ctrl.lo_in;
    assign con_in     = ctrl.con_in;
    assign outport_in = ctrl.outport_in;
    assign gra        = ctrl.gra;
    assign grb        = ctrl.grb;
    assign grc        = ctrl.grc;
    assign r_in       = ctrl.r_in;
    assign r_out      = ctrl.r_out;
    assign ba_out     = ctrl.ba_out;
    assign read       = ctrl.read;
    assign write      = ctrl.write;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios with literal
// expectations plus randomized instruction streams against a microprogram
// queue model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = 32'h18918000;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;

    logic [4:0] alu_opcode;
    logic run, inc_pc, br_flag, pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out;
    logic inport_out, c_out, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic con_in, outport_in, gra, grb, grc, r_in, r_out, ba_out, read, write;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .run(run), .alu_opcode(alu_opcode), .inc_pc(inc_pc), .br_flag(br_flag),
        .pc_out(pc_out), .mdr_out(mdr_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .hi_out(hi_out), .lo_out(lo_out), .inport_out(inport_out), .c_out(c_out),
        .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in),
        .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .con_in(con_in),
        .outport_in(outport_in), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
        .r_out(r_out), .ba_out(ba_out), .read(read), .write(write)
    );

    // Bit positions of the 1-bit outputs in the comparison vector.
    localparam logic [28:0] B_RUN = 29'h1 << 0,  B_INC_PC = 29'h1 << 1,  B_BR_FLAG = 29'h1 << 2;
    localparam logic [28:0] B_PC_OUT = 29'h1 << 3, B_MDR_OUT = 29'h1 << 4, B_ZHI_OUT = 29'h1 << 5;
    localparam logic [28:0] B_ZLO_OUT = 29'h1 << 6, B_HI_OUT = 29'h1 << 7, B_LO_OUT = 29'h1 << 8;
    localparam logic [28:0] B_INPORT_OUT = 29'h1 << 9, B_C_OUT = 29'h1 << 10, B_PC_IN = 29'h1 << 11;
    localparam logic [28:0] B_MAR_IN = 29'h1 << 12, B_MDR_IN = 29'h1 << 13, B_IR_IN = 29'h1 << 14;
    localparam logic [28:0] B_Y_IN = 29'h1 << 15, B_Z_IN = 29'h1 << 16, B_HI_IN = 29'h1 << 17;
    localparam logic [28:0] B_LO_IN = 29'h1 << 18, B_CON_IN = 29'h1 << 19, B_OUTPORT_IN = 29'h1 << 20;
    localparam logic [28:0] B_GRA = 29'h1 << 21, B_GRB = 29'h1 << 22, B_GRC = 29'h1 << 23;
    localparam logic [28:0] B_R_IN = 29'h1 << 24, B_R_OUT = 29'h1 << 25, B_BA_OUT = 29'h1 << 26;
    localparam logic [28:0] B_READ = 29'h1 << 27, B_WRITE = 29'h1 << 28;
    localparam logic [28:0] T0_PAT = B_RUN | B_PC_OUT | B_MAR_IN | B_INC_PC | B_PC_IN;
    localparam logic [4:0]  A_NOP = 5'd26, A_ADD = 5'd3;

    logic [28:0] dut_vec;
    assign dut_vec = {write, read, ba_out, r_out, r_in, grc, grb, gra, outport_in, con_in,
                      lo_in, hi_in, z_in, y_in, ir_in, mdr_in, mar_in, pc_in, c_out,
                      inport_out, lo_out, hi_out, zlo_out, zhi_out, mdr_out, pc_out,
                      br_flag, inc_pc, run};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: a queue of remaining micro-steps ----------------
    typedef struct {
        logic [28:0] m;    // strobes always asserted in this step
        logic [28:0] cm;   // strobes asserted only when con_ff = 1
        logic [4:0]  alu;
    } step_t;
    typedef enum {M_RESET, M_RUN, M_HALT} mode_e;

    mode_e      m_mode = M_RESET;
    step_t      m_q[$];
    bit         m_exec = 1'b0;
    logic [4:0] m_op = 5'd0;

    task automatic push(input logic [28:0] m, input logic [4:0] alu, input logic [28:0] cm);
        step_t s;
        s.m = m; s.cm = cm; s.alu = alu;
        m_q.push_back(s);
    endtask

    task automatic load_fetch();
        m_exec = 1'b0;
        push(B_PC_OUT | B_MAR_IN | B_INC_PC | B_PC_IN, A_NOP, '0);
        push(B_READ | B_MDR_IN, A_NOP, '0);
        push(B_MDR_OUT | B_IR_IN, A_NOP, '0);
    endtask

    task automatic load_exec(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                push(B_GRB | B_R_OUT | B_Y_IN, A_NOP, '0);
                push(B_GRC | B_R_OUT | B_Z_IN, op, '0);
                push(B_ZLO_OUT | B_GRA | B_R_IN, A_NOP, '0);
            end
            5'd12, 5'd13, 5'd14: begin
                push(B_GRB | B_R_OUT | B_Y_IN, A_NOP, '0);
                push(B_C_OUT | B_Z_IN, op, '0);
                push(B_ZLO_OUT | B_GRA | B_R_IN, A_NOP, '0);
            end
            5'd15, 5'd16: begin
                push(B_GRA | B_R_OUT | B_Y_IN, A_NOP, '0);
                push(B_GRB | B_R_OUT | B_Z_IN, op, '0);
                push(B_ZLO_OUT | B_LO_IN, A_NOP, '0);
                push(B_ZHI_OUT | B_HI_IN, A_NOP, '0);
            end
            5'd17, 5'd18: begin
                push(B_GRB | B_R_OUT | B_Z_IN, op, '0);
                push(B_ZLO_OUT | B_GRA | B_R_IN, A_NOP, '0);
            end
            5'd0, 5'd1, 5'd2: begin
                push(B_GRB | B_BA_OUT | B_Y_IN, A_NOP, '0);
                push(B_C_OUT | B_Z_IN, A_ADD, '0);
                if (op == 5'd1) begin
                    push(B_ZLO_OUT | B_GRA | B_R_IN, A_NOP, '0);
                end else if (op == 5'd0) begin
                    push(B_ZLO_OUT | B_MAR_IN, A_NOP, '0);
                    push(B_READ | B_MDR_IN, A_NOP, '0);
                    push(B_MDR_OUT | B_GRA | B_R_IN, A_NOP, '0);
                end else begin
                    push(B_ZLO_OUT | B_MAR_IN, A_NOP, '0);
                    push(B_GRA | B_R_OUT | B_MDR_IN, A_NOP, '0);
                    push(B_WRITE, A_NOP, '0);
                end
            end
            5'd19: begin
                push(B_GRA | B_R_OUT | B_CON_IN, A_NOP, '0);
                push(B_PC_OUT | B_Y_IN, A_NOP, '0);
                push(B_C_OUT | B_Z_IN, A_ADD, B_BR_FLAG);
                push('0, A_NOP, B_PC_IN | B_ZLO_OUT | B_BR_FLAG);
            end
            5'd20: push(B_GRA | B_R_OUT | B_PC_IN, A_NOP, '0);
            5'd21: begin
                push(B_PC_OUT | B_GRB | B_R_IN, A_NOP, '0);
                push(B_GRA | B_R_OUT | B_PC_IN, A_NOP, '0);
            end
            5'd22: push(B_INPORT_OUT | B_GRA | B_R_IN, A_NOP, '0);
            5'd23: push(B_GRA | B_R_OUT | B_OUTPORT_IN, A_NOP, '0);
            5'd24: push(B_HI_OUT | B_GRA | B_R_IN, A_NOP, '0);
            5'd25: push(B_LO_OUT | B_GRA | B_R_IN, A_NOP, '0);
            default: push('0, A_NOP, '0);  // NOP, HALT and undefined opcodes: one idle step
        endcase
    endtask

    // Model advance: consume one micro-step per clock; an empty queue ends a phase.
    initial begin
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                m_mode = M_RESET;
                m_q.delete();
                m_exec = 1'b0;
            end else begin
                case (m_mode)
                    M_RESET: begin
                        m_mode = M_RUN;
                        load_fetch();
                    end
                    M_RUN: begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            if (!m_exec) begin
                                m_exec = 1'b1;
                                m_op   = ir[31:27];
                                load_exec(m_op);
                            end else if (m_op == 5'd27 || stop) begin
                                m_mode = M_HALT;
                            end else begin
                                load_fetch();
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic bit model_at_t0();
        return m_mode == M_RUN && !m_exec && m_q.size() == 3;
    endfunction

    // Compare every cycle on the falling edge, away from state updates and input changes.
    initial begin
        logic [28:0] exp_v;
        logic [4:0]  exp_a;
        forever begin
            @(negedge clk);
            exp_v = '0;
            exp_a = '0;
            if (m_mode == M_RUN && m_q.size() != 0) begin
                exp_v = m_q[0].m | (con_ff ? m_q[0].cm : 29'h0) | B_RUN;
                exp_a = m_q[0].alu;
            end
            check("cycle", {29'h0, alu_opcode, dut_vec}, {29'h0, exp_a, exp_v});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int halt_cnt;

        // Reset, then abort an ADD in T4.
        ticks(2);
        check("rst_idle", {alu_opcode, dut_vec}, 34'h0);
        clr = 1'b0;
        tick();
        check("t0_after_rst", dut_vec, T0_PAT);
        ticks(4);
        check("add_t4", dut_vec, B_RUN | B_GRC | B_R_OUT | B_Z_IN);
        check("add_t4_alu", alu_opcode, 5'b00011);
        clr = 1'b1;
        #1;
        check("clr_mid_t4", {alu_opcode, dut_vec}, 34'h0);
        tick();
        clr = 1'b0;
        tick();
        check("t0_restart", dut_vec, T0_PAT);

        // ADD: six cycles.
        ticks(5);
        check("add_t5", dut_vec, B_RUN | B_ZLO_OUT | B_GRA | B_R_IN);
        tick();
        check("add_next_t0", dut_vec, T0_PAT);

        // MUL: seven cycles.
        ir = 32'h78000000;
        ticks(5);
        check("mul_t5", dut_vec, B_RUN | B_ZLO_OUT | B_LO_IN);
        tick();
        check("mul_t6", dut_vec, B_RUN | B_ZHI_OUT | B_HI_IN);
        tick();
        check("mul_next_t0", dut_vec, T0_PAT);

        // BRANCH not taken, then taken.
        ir = 32'h98000000;
        con_ff = 1'b0;
        ticks(5);
        check("br0_t5", dut_vec, B_RUN | B_C_OUT | B_Z_IN);
        tick();
        check("br0_t6", dut_vec, B_RUN);
        tick();
        con_ff = 1'b1;
        ticks(5);
        check("br1_t5", dut_vec, B_RUN | B_C_OUT | B_Z_IN | B_BR_FLAG);
        check("br1_t5_alu", alu_opcode, 5'b00011);
        tick();
        check("br1_t6", dut_vec, B_RUN | B_PC_IN | B_ZLO_OUT | B_BR_FLAG);
        tick();
        check("br_next_t0", dut_vec, T0_PAT);
        con_ff = 1'b0;

        // LD: eight cycles.
        ir = 32'h00000000;
        ticks(6);
        check("ld_t6", dut_vec, B_RUN | B_READ | B_MDR_IN);
        tick();
        check("ld_t7", dut_vec, B_RUN | B_MDR_OUT | B_GRA | B_R_IN);
        tick();
        check("ld_next_t0", dut_vec, T0_PAT);

        // ST: never reads during execute, writes in T7.
        ir = 32'h10000000;
        ticks(3);
        for (int i = 0; i < 5; i++) begin
            check("st_no_read", read, 1'b0);
            if (i < 4) tick();
        end
        check("st_t7", dut_vec, B_RUN | B_WRITE);
        tick();
        check("st_next_t0", dut_vec, T0_PAT);

        // stop raised in T1 of an ADD: ADD finishes, then HALTED.
        ir = 32'h18918000;
        tick();
        stop = 1'b1;
        ticks(4);
        check("stop_add_t5", dut_vec, B_RUN | B_ZLO_OUT | B_GRA | B_R_IN);
        tick();
        check("stop_halted", {alu_opcode, dut_vec}, 34'h0);
        stop = 1'b0;

        // HALT instruction holds until clr.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        ir = 32'hD8000000;
        ticks(3);
        check("halt_t3", {alu_opcode, dut_vec}, {A_NOP, B_RUN});
        tick();
        check("halt_entered", run, 1'b0);
        ticks(20);
        check("halt_held", {alu_opcode, dut_vec}, 34'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("halt_restart_t0", dut_vec, T0_PAT);

        // Randomized instruction stream; the per-cycle compare does the checking.
        halt_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            con_ff = 1'($urandom_range(0, 1));
            stop   = ($urandom_range(0, 15) == 0);
            if (model_at_t0()) ir = {5'($urandom_range(0, 31)), 27'($urandom)};
            if (m_mode == M_HALT) halt_cnt++;
            if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                halt_cnt = 0;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
